// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
//   Shared types and constants for the ALU operation scheduler.
//   - sched_state_e : scheduler FSM states
//   - CLS_*         : op class encodings taken from sel[4:3]
//   - DEFAULT_TIMEOUT : default arithmetic wait limit in cycles
//   - op_class()    : extracts the class field from a 5-bit select

package alu_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWait,
        StResp
    } sched_state_e;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;
    localparam logic [1:0] CLS_RSVD  = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT = 256;

    function automatic logic [1:0] op_class(input logic [4:0] sel);
        return sel[4:3];
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
//   Two-way round-robin arbiter, purely combinational.
//   Ports:
//     req_i        : per-requester request
//     last_grant_i : ID of the requester granted most recently
//     grant_o      : one-hot grant (all zero when nothing requests)
//     winner_o     : ID of the granted requester (0 when nothing requests)

module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        grant_o  = 2'b00;
        winner_o = 1'b0;
        unique case (req_i)
            2'b01: begin
                grant_o  = 2'b01;
                winner_o = 1'b0;
            end
            2'b10: begin
                grant_o  = 2'b10;
                winner_o = 1'b1;
            end
            2'b11: begin
                // Contention: whoever was not served last goes next.
                winner_o = ~last_grant_i;
                grant_o  = last_grant_i ? 2'b01 : 2'b10;
            end
            default: begin
                grant_o  = 2'b00;
                winner_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Arbitrates two requesters onto one shared ALU, sequences the operation
//   according to its class and returns the result on a response channel.
//   Ports:
//     clk, rst_b                  : clock, async active-low reset
//     req_valid / req_ready       : per-requester request handshake
//     req{0,1}_in_{0,1}, _sel     : requester operands and op select
//     rsp_valid / rsp_ready       : response handshake
//     rsp_id, rsp_data, rsp_err   : response owner, result, error flag
//     alu_bgn, alu_in_*, alu_sel  : drive the ALU
//     alu_stop, alu_out           : ALU completion and result

module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_b,

    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_in_0,
    input  logic [DATA_W-1:0] req0_in_1,
    input  logic [4:0]        req0_sel,
    input  logic [DATA_W-1:0] req1_in_0,
    input  logic [DATA_W-1:0] req1_in_1,
    input  logic [4:0]        req1_sel,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,

    output logic              alu_bgn,
    output logic [DATA_W-1:0] alu_in_0,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [4:0]        alu_sel,
    input  logic              alu_stop,
    input  logic [DATA_W-1:0] alu_out
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        arb_grant;
    logic              arb_winner;
    logic [4:0]        win_sel;

    sched_state_e      state_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] in0_q;
    logic [DATA_W-1:0] in1_q;
    logic [4:0]        sel_q;
    logic              id_q;
    logic [DATA_W-1:0] result_q;
    logic              err_q;
    logic              rsp_valid_q;
    logic              alu_bgn_q;
    logic [CNT_W-1:0]  cnt_q;

    rr_arbiter_2 u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .winner_o     (arb_winner)
    );

    assign win_sel = arb_winner ? req1_sel : req0_sel;

    // Grant is only offered in IDLE; gating with rst_b keeps it low while
    // reset is held even if requesters keep their valid asserted.
    assign req_ready = ((state_q == StIdle) && rst_b) ? arb_grant : 2'b00;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            in0_q        <= '0;
            in1_q        <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            alu_bgn_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            alu_bgn_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_grant != 2'b00) begin
                        in0_q     <= arb_winner ? req1_in_0 : req0_in_0;
                        in1_q     <= arb_winner ? req1_in_1 : req0_in_1;
                        sel_q     <= win_sel;
                        id_q      <= arb_winner;
                        // Registered start pulse: raised on accept so it is
                        // visible for exactly the EXEC cycle.
                        alu_bgn_q <= (op_class(win_sel) == CLS_ARITH);
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    unique case (op_class(sel_q))
                        CLS_ARITH: begin
                            cnt_q   <= '0;
                            state_q <= StWait;
                        end
                        CLS_LOGIC, CLS_SHIFT: begin
                            // Single-cycle units: ALU output is already valid.
                            result_q    <= alu_out;
                            err_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                        CLS_RSVD: begin
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    endcase
                end
                StWait: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (alu_stop) begin
                        result_q    <= alu_out;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= id_q;
                        state_q      <= StIdle;
                    end
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = result_q;
    assign rsp_err   = err_q;
    assign alu_bgn   = alu_bgn_q;
    assign alu_in_0  = in0_q;
    assign alu_in_1  = in1_q;
    assign alu_sel   = sel_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_in_0 = '0, req0_in_1 = '0, req1_in_0 = '0, req1_in_1 = '0;
    logic [4:0]    req0_sel = '0, req1_sel = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          alu_bgn, alu_stop;
    logic [DW-1:0] alu_in_0, alu_in_1, alu_out;
    logic [4:0]    alu_sel;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bgn_cyc = -1000;
    int bgn_count = 0;
    int stop_dly = 0;
    logic stray_stop = 1'b0;
    bit model_last = 1'b1;

    alu_op_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_in_0 (req0_in_0),
        .req0_in_1 (req0_in_1),
        .req0_sel  (req0_sel),
        .req1_in_0 (req1_in_0),
        .req1_in_1 (req1_in_1),
        .req1_sel  (req1_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .alu_bgn   (alu_bgn),
        .alu_in_0  (alu_in_0),
        .alu_in_1  (alu_in_1),
        .alu_sel   (alu_sel),
        .alu_stop  (alu_stop),
        .alu_out   (alu_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU
    function automatic logic [DW-1:0] alu_f(input logic [4:0] sel, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [2:0] op;
        op = sel[2:0];
        case (sel[4:3])
            CLS_ARITH: return op[0] ? a - b : a + b;
            CLS_LOGIC: begin
                case (op)
                    3'd0:    return a & b;
                    3'd1:    return a | b;
                    3'd2:    return a ^ b;
                    default: return ~(a & b);
                endcase
            end
            CLS_SHIFT: return op[0] ? (a >> b[5:0]) : (a << b[5:0]);
            default:   return 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_sel, alu_in_0, alu_in_1);
    assign alu_stop = stray_stop | ((stop_dly != 0) && (cyc == bgn_cyc + stop_dly));

    always @(posedge clk) begin
        if (alu_bgn) begin
            bgn_cyc   <= cyc;
            bgn_count <= bgn_count + 1;
        end
    end

    always @(negedge clk) begin
        total++;
        assert (req_ready !== 2'b11) else begin
            bad++;
            $error("FAIL ready_onehot observed=%b expected=not 11", req_ready);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [4:0] sel);
        if (id) begin
            req1_in_0 = a; req1_in_1 = b; req1_sel = sel;
        end else begin
            req0_in_0 = a; req0_in_1 = b; req0_sel = sel;
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_ctl"}, 64'({req_ready, rsp_valid, rsp_id, rsp_err, alu_bgn, alu_sel}), 64'd0);
        chk({pfx, "_data"}, rsp_data, 64'd0);
        chk({pfx, "_in0"}, alu_in_0, 64'd0);
        chk({pfx, "_in1"}, alu_in_1, 64'd0);
    endtask

    // One operation from one requester; dly = cycles from alu_bgn to alu_stop
    // (0 = never), hold = cycles of response back-pressure.
    task automatic run_op(input bit id, input logic [4:0] sel, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int dly, input int hold);
        int acc, lat_exp, b0;
        logic [DW-1:0] d_exp;
        logic e_exp;
        bit got;
        if (sel[4:3] == CLS_RSVD) begin
            lat_exp = 2; d_exp = '0; e_exp = 1'b1;
        end else if (sel[4:3] != CLS_ARITH) begin
            lat_exp = 2; d_exp = alu_f(sel, a, b); e_exp = 1'b0;
        end else if (dly >= 1 && dly <= TO) begin
            lat_exp = 2 + dly; d_exp = alu_f(sel, a, b); e_exp = 1'b0;
        end else begin
            lat_exp = 2 + TO; d_exp = '0; e_exp = 1'b1;
        end
        @(negedge clk);
        stop_dly   = dly;
        stray_stop = (sel[4:3] != CLS_ARITH) && ($urandom_range(0, 1) == 1);
        rsp_ready  = 1'b0;
        drive_req(id, a, b, sel);
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready[id]) begin got = 1; break; end
            @(negedge clk); #1;
        end
        chk("accept_seen", 64'(got), 64'd1);
        if (!got) begin req_valid = 2'b00; return; end
        chk("accept_grant", 64'(req_ready), id ? 64'd2 : 64'd1);
        acc = cyc;
        b0  = bgn_count;
        @(negedge clk);
        req_valid = 2'b00;
        drive_req(id, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
        got = 0;
        for (int i = 0; i < TO + 8; i++) begin
            if (rsp_valid) begin got = 1; break; end
            @(negedge clk);
        end
        chk("rsp_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("rsp_latency", 64'(cyc - acc), 64'(lat_exp));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("rsp_data", rsp_data, d_exp);
        chk("rsp_err", 64'(rsp_err), 64'(e_exp));
        chk("bgn_pulses", 64'(bgn_count - b0), (sel[4:3] == CLS_ARITH) ? 64'd1 : 64'd0);
        chk("alu_in_0", alu_in_0, a);
        chk("alu_in_1", alu_in_1, b);
        chk("alu_sel", 64'(alu_sel), 64'(sel));
        if (hold > 0) req_valid = 2'b11;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", rsp_data, d_exp);
            chk("bp_err", 64'(rsp_err), 64'(e_exp));
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_in0", alu_in_0, a);
            chk("bp_in1", alu_in_1, b);
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready  = 1'b0;
        stray_stop = 1'b0;
        chk("post_hs_valid", 64'(rsp_valid), 64'd0);
        model_last = id;
    endtask

    // Both requesters keep valid high; only the winner replaces its op.
    task automatic contention(input int n_ops);
        logic [DW-1:0] pa[2], pb[2], ea, eb;
        logic [4:0] ps[2], es;
        bit w, got;
        int acc;
        for (int r = 0; r < 2; r++) begin
            pa[r] = {$urandom, $urandom};
            pb[r] = {$urandom, $urandom};
            ps[r] = {($urandom_range(0, 1) == 1) ? CLS_SHIFT : CLS_LOGIC, 3'($urandom)};
        end
        w = ~model_last;
        @(negedge clk);
        stop_dly  = 0;
        rsp_ready = 1'b1;
        drive_req(1'b0, pa[0], pb[0], ps[0]);
        drive_req(1'b1, pa[1], pb[1], ps[1]);
        req_valid = 2'b11;
        for (int k = 0; k < n_ops; k++) begin
            #1;
            got = 0;
            for (int i = 0; i < 8; i++) begin
                if (req_ready != 2'b00) begin got = 1; break; end
                @(negedge clk); #1;
            end
            chk("cont_grant", 64'(req_ready), w ? 64'd2 : 64'd1);
            if (!got) break;
            acc = cyc;
            ea = pa[w]; eb = pb[w]; es = ps[w];
            @(negedge clk);
            pa[w] = {$urandom, $urandom};
            pb[w] = {$urandom, $urandom};
            ps[w] = {($urandom_range(0, 1) == 1) ? CLS_SHIFT : CLS_LOGIC, 3'($urandom)};
            drive_req(w, pa[w], pb[w], ps[w]);
            got = 0;
            for (int i = 0; i < 8; i++) begin
                if (rsp_valid) begin got = 1; break; end
                @(negedge clk);
            end
            chk("cont_rsp_seen", 64'(got), 64'd1);
            if (!got) break;
            chk("cont_latency", 64'(cyc - acc), 64'd2);
            chk("cont_id", 64'(rsp_id), 64'(w));
            chk("cont_data", rsp_data, alu_f(es, ea, eb));
            chk("cont_err", 64'(rsp_err), 64'd0);
            model_last = w;
            w = ~w;
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

    initial begin
        bit got;
        #2 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_b = 1'b1;
        model_last = 1'b1;

        // Directed: logic AND from requester 0
        run_op(1'b0, 5'b01_000, 64'hFF00, 64'h0FF0, 0, 0);
        // Directed: arithmetic from requester 1, stop 10 cycles after bgn
        run_op(1'b1, 5'b00_001, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1111, 10, 0);
        // Contention alternation
        contention(4);
        // Reserved class
        run_op(1'b0, 5'b11_000, 64'h55, 64'hAA, 0, 0);
        // Timeout: stop never arrives
        run_op(1'b1, 5'b00_000, 64'h7, 64'h9, 0, 0);
        // Stop arrives on the last counted cycle: completion wins
        run_op(1'b0, 5'b00_000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, TO, 0);
        // Stop one cycle too late: timeout
        run_op(1'b1, 5'b00_001, 64'h100, 64'h1, TO + 1, 0);
        // Back-pressure, then the next grant follows the handshake
        run_op(1'b0, 5'b01_010, 64'hF0F0_0000_1234_0000, 64'h0FF0_FFFF_0000_4321, 0, 5);
        contention(2);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            run_op(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, TO + 3), $urandom_range(0, 3));
        end

        // Reset in the middle of WAIT
        @(negedge clk);
        stop_dly = 0;
        drive_req(1'b1, 64'h33, 64'h44, 5'b00_000);
        req_valid = 2'b10;
        #1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready[1]) begin got = 1; break; end
            @(negedge clk); #1;
        end
        chk("rst_op_accept", 64'(got), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        rst_b = 1'b0;
        #1;
        check_zero("midwait_reset");
        repeat (2) @(negedge clk);
        chk("reset_no_rsp", 64'(rsp_valid), 64'd0);
        chk("reset_ready_low", 64'(req_ready), 64'd0);
        rst_b = 1'b1;
        #1;
        chk("reset_first_winner", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        model_last = 1'b1;
        contention(2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
